count_seq_ctrl: RTL and testbench

//  Run controller for a DIGITS-bit binary counter.

---
 rtl/count_seq_ctrl_pkg.sv | 23 ++
 rtl/count_seq_ctrl_ctr_core.sv | 64 ++++++
 rtl/count_seq_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_count_seq_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_seq_ctrl_pkg.sv
// count_seq_ctrl_pkg
//   Shared definitions for the counter run controller: FSM state encoding,
//   mode constants and a small state-decoding helper.
//   No ports (package).
package count_seq_ctrl_pkg;

  // FSM state encoding (3-bit, kept as plain constants for legacy tools)
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Run modes latched in LOAD
  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_FREERUN = 1'b1;

  // A sequence is in progress in every state except IDLE
  function automatic logic state_is_busy(input logic [2:0] st);
    return (st != ST_IDLE);
  endfunction

endpackage

// File: rtl/count_seq_ctrl_ctr_core.sv
// ctr_core
//   DIGITS-bit counter register with asynchronous clear, synchronous load
//   (load has priority over enable) and an enable that steps the count by
//   one, modulo 2**DIGITS.
//   Optional feature macro: COUNT_SEQ_DOWN_EN adds a direction input.
// Ports
//   clock    in   rising-edge clock
//   reset_n  in   asynchronous active-low clear
//   load     in   load load_val this cycle
//   load_val in   value to load
//   enable   in   step the count this cycle
//   down     in   (COUNT_SEQ_DOWN_EN only) 1 = step down, 0 = step up
//   count    out  registered count
module ctr_core #(
  parameter int DIGITS = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic [DIGITS-1:0] load_val,
  input  logic              enable,
`ifdef COUNT_SEQ_DOWN_EN
  input  logic              down,
`endif
  output logic [DIGITS-1:0] count
);

  localparam logic [DIGITS-1:0] ONE = DIGITS'(1);

  logic [DIGITS-1:0] count_d;
  logic [DIGITS-1:0] count_q;

  // Next count: load wins over step; arithmetic wraps naturally at DIGITS bits
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (enable) begin
`ifdef COUNT_SEQ_DOWN_EN
      if (down) begin
        count_d = count_q - ONE;
      end else begin
        count_d = count_q + ONE;
      end
`else
      count_d = count_q + ONE;
`endif
    end else begin
      count_d = count_q;
    end
  end

  // Count register with asynchronous clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl
//   Run controller for a DIGITS-bit counter: sequences load, run, pause,
//   terminal count and restart, and emits registered status pulses.
//   Optional feature macro: COUNT_SEQ_DOWN_EN adds the 'down' input, latched
//   in LOAD, which makes RUN count downwards.
// Ports
//   clock    in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   start    in   IDLE: begin a sequence; PAUSE: resume
//   halt     in   RUN: pause counting
//   abort    in   synchronous return to IDLE from any state (count cleared)
//   mode     in   0 one-shot, 1 free-run (latched in LOAD)
//   load_val in   start value (latched in LOAD)
//   limit    in   terminal value (latched in LOAD)
//   down     in   (COUNT_SEQ_DOWN_EN only) count direction (latched in LOAD)
//   count    out  current count
//   busy     out  high in LOAD, RUN, PAUSE, DONE
//   done     out  one-cycle pulse on one-shot completion
//   wrap     out  one-cycle pulse on a free-run reload
module count_seq_ctrl
  import count_seq_ctrl_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              halt,
  input  logic              abort,
  input  logic              mode,
  input  logic [DIGITS-1:0] load_val,
  input  logic [DIGITS-1:0] limit,
`ifdef COUNT_SEQ_DOWN_EN
  input  logic              down,
`endif
  output logic [DIGITS-1:0] count,
  output logic              busy,
  output logic              done,
  output logic              wrap
);

  logic [2:0]        state_d, state_q;
  logic              mode_d, mode_q;
  logic [DIGITS-1:0] limit_d, limit_q;
  logic [DIGITS-1:0] load_val_d, load_val_q;
  logic              busy_d, busy_q;
  logic              done_d, done_q;
  logic              wrap_d, wrap_q;
`ifdef COUNT_SEQ_DOWN_EN
  logic              down_d, down_q;
`endif

  logic              core_load;
  logic [DIGITS-1:0] core_val;
  logic              core_en;
  logic              terminal;

  // Terminal test uses the count as it stands, before any step this cycle
  assign terminal = (count == limit_q);

  // FSM next state, counter commands, pulse generation and input latching
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    limit_d    = limit_q;
    load_val_d = load_val_q;
`ifdef COUNT_SEQ_DOWN_EN
    down_d     = down_q;
`endif
    done_d     = 1'b0;
    wrap_d     = 1'b0;
    core_load  = 1'b0;
    core_val   = '0;
    core_en    = 1'b0;
    if (abort) begin
      // Highest priority: clear the count via a load of zero; pulses dropped
      state_d   = ST_IDLE;
      core_load = 1'b1;
      core_val  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_LOAD: begin
          core_load  = 1'b1;
          core_val   = load_val;
          mode_d     = mode;
          limit_d    = limit;
          load_val_d = load_val;
`ifdef COUNT_SEQ_DOWN_EN
          down_d     = down;
`endif
          state_d    = ST_RUN;
        end
        ST_RUN: begin
          if (halt) begin
            // Pause wins over the terminal action, which is simply deferred
            state_d = ST_PAUSE;
          end else if (terminal) begin
            if (mode_q == MODE_ONESHOT) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              core_load = 1'b1;
              core_val  = load_val_q;
              wrap_d    = 1'b1;
            end
          end else begin
            core_en = 1'b1;
          end
        end
        ST_PAUSE: begin
          if (start) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_PAUSE;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          // Unreachable encodings recover to a clean IDLE
          state_d   = ST_IDLE;
          core_load = 1'b1;
          core_val  = '0;
        end
      endcase
    end
    busy_d = state_is_busy(state_d);
  end

  // State, latched configuration and registered status outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      mode_q     <= 1'b0;
      limit_q    <= '0;
      load_val_q <= '0;
`ifdef COUNT_SEQ_DOWN_EN
      down_q     <= 1'b0;
`endif
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      limit_q    <= limit_d;
      load_val_q <= load_val_d;
`ifdef COUNT_SEQ_DOWN_EN
      down_q     <= down_d;
`endif
      busy_q     <= busy_d;
      done_q     <= done_d;
      wrap_q     <= wrap_d;
    end
  end

  ctr_core #(
    .DIGITS(DIGITS)
  ) u_core (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (core_load),
    .load_val(core_val),
    .enable  (core_en),
`ifdef COUNT_SEQ_DOWN_EN
    .down    (down_q),
`endif
    .count   (count)
  );

  assign busy = busy_q;
  assign done = done_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// tb_count_seq_ctrl
//   Self-checking bench for count_seq_ctrl: directed scenarios with
//   hand-derived expected sequences plus a randomized run checked against a
//   behavioural model that tracks the sequence phase and the count as integers.
module tb_count_seq_ctrl;

  localparam int DIGITS = 3;
  localparam int MODV   = 8;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       halt = 1'b0;
  logic       abort = 1'b0;
  logic       mode = 1'b0;
  logic [2:0] load_val = 3'd0;
  logic [2:0] limit = 3'd0;
`ifdef COUNT_SEQ_DOWN_EN
  logic       down = 1'b0;
`endif
  logic [2:0] count;
  logic       busy;
  logic       done;
  logic       wrap;

  int checks = 0;
  int failures = 0;

  count_seq_ctrl #(.DIGITS(DIGITS)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .halt    (halt),
    .abort   (abort),
    .mode    (mode),
    .load_val(load_val),
    .limit   (limit),
`ifdef COUNT_SEQ_DOWN_EN
    .down    (down),
`endif
    .count   (count),
    .busy    (busy),
    .done    (done),
    .wrap    (wrap)
  );

  always #5 clock = ~clock;

  // Behavioural reference model
  typedef enum int {P_IDLE, P_LOAD, P_RUN, P_PAUSE, P_DONE} phase_t;
  phase_t m_phase = P_IDLE;
  int     m_count = 0;
  int     m_lv = 0;
  int     m_limit = 0;
  int     m_mode = 0;
  int     m_down = 0;
  bit     m_busy = 1'b0;
  bit     m_done = 1'b0;
  bit     m_wrap = 1'b0;

  task automatic model_reset();
    m_phase = P_IDLE; m_count = 0; m_lv = 0; m_limit = 0; m_mode = 0; m_down = 0;
    m_busy = 1'b0; m_done = 1'b0; m_wrap = 1'b0;
  endtask

  task automatic model_edge();
    phase_t np = m_phase;
    int     nc = m_count;
    bit     nd = 1'b0;
    bit     nw = 1'b0;
    if (abort) begin
      np = P_IDLE;
      nc = 0;
    end else begin
      case (m_phase)
        P_IDLE:  if (start) np = P_LOAD;
        P_LOAD: begin
          nc = int'(load_val); m_lv = int'(load_val); m_limit = int'(limit);
          m_mode = int'(mode);
`ifdef COUNT_SEQ_DOWN_EN
          m_down = int'(down);
`endif
          np = P_RUN;
        end
        P_RUN: begin
          if (halt) np = P_PAUSE;
          else if (m_count == m_limit) begin
            if (m_mode == 1) begin nc = m_lv; nw = 1'b1; end
            else begin np = P_DONE; nd = 1'b1; end
          end else if (m_down == 1) nc = (m_count + MODV - 1) % MODV;
          else nc = (m_count + 1) % MODV;
        end
        P_PAUSE: if (start) np = P_RUN;
        default: np = P_IDLE;
      endcase
    end
    m_phase = np; m_count = nc; m_done = nd; m_wrap = nw;
    m_busy = (np != P_IDLE);
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic begin_seq(input bit md, input logic [2:0] lv, input logic [2:0] lim);
    mode = md; load_val = lv; limit = lim; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic stop_seq();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++;
    if ({done, wrap} !== 2'b00) begin failures++; $display("FAIL reset_pulses got=%b exp=00", {done, wrap}); end
    checks++;
    @(posedge clock); #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_oneshot();
    logic [2:0] ec [0:5];
    logic       ed [0:5];
    logic       eb [0:5];
    ec = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd5};
    ed = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    eb = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    begin_seq(1'b0, 3'd2, 3'd5);
    for (int i = 0; i < 6; i++) begin
      if (count !== ec[i]) begin failures++; $display("FAIL oneshot_count[%0d] got=%0d exp=%0d", i, count, ec[i]); end
      checks++;
      if (done !== ed[i] || wrap !== 1'b0) begin failures++; $display("FAIL oneshot_pulse[%0d] got done=%0b wrap=%0b exp done=%0b wrap=0", i, done, wrap, ed[i]); end
      checks++;
      if (busy !== eb[i]) begin failures++; $display("FAIL oneshot_busy[%0d] got=%0b exp=%0b", i, busy, eb[i]); end
      checks++;
      tick();
    end
  endtask

  task automatic test_freerun();
    logic [2:0] ec [0:7];
    logic       ew [0:7];
    ec = '{3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3, 3'd1, 3'd2};
    ew = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    begin_seq(1'b1, 3'd1, 3'd3);
    for (int i = 0; i < 8; i++) begin
      if (count !== ec[i]) begin failures++; $display("FAIL freerun_count[%0d] got=%0d exp=%0d", i, count, ec[i]); end
      checks++;
      if (wrap !== ew[i] || done !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL freerun_flags[%0d] got wrap=%0b done=%0b busy=%0b exp wrap=%0b done=0 busy=1", i, wrap, done, busy, ew[i]); end
      checks++;
      tick();
    end
    stop_seq();
  endtask

  task automatic test_halt();
    begin_seq(1'b0, 3'd0, 3'd7);
    tick(); tick(); tick();
    if (count !== 3'd3) begin failures++; $display("FAIL halt_pre got=%0d exp=3", count); end
    checks++;
    halt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (count !== 3'd3 || busy !== 1'b1) begin failures++; $display("FAIL halt_hold[%0d] got count=%0d busy=%0b exp count=3 busy=1", i, count, busy); end
      checks++;
    end
    halt = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    if (count !== 3'd3 || busy !== 1'b1) begin failures++; $display("FAIL halt_resume got count=%0d busy=%0b exp count=3 busy=1", count, busy); end
    checks++;
    tick();
    if (count !== 3'd4) begin failures++; $display("FAIL halt_step got=%0d exp=4", count); end
    checks++;
    stop_seq();
  endtask

  task automatic test_wrap_boundary();
    logic [2:0] ec [0:5];
    logic       ed [0:5];
    ec = '{3'd6, 3'd7, 3'd0, 3'd1, 3'd1, 3'd1};
    ed = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    begin_seq(1'b0, 3'd6, 3'd1);
    for (int i = 0; i < 6; i++) begin
      if (count !== ec[i] || done !== ed[i]) begin failures++; $display("FAIL wrapbound[%0d] got count=%0d done=%0b exp count=%0d done=%0b", i, count, done, ec[i], ed[i]); end
      checks++;
      tick();
    end
  endtask

  task automatic test_equal_limit();
    begin_seq(1'b0, 3'd4, 3'd4);
    if (count !== 3'd4 || done !== 1'b0) begin failures++; $display("FAIL equal_first got count=%0d done=%0b exp count=4 done=0", count, done); end
    checks++;
    tick();
    if (count !== 3'd4 || done !== 1'b1) begin failures++; $display("FAIL equal_done got count=%0d done=%0b exp count=4 done=1", count, done); end
    checks++;
    tick();
  endtask

  task automatic test_abort();
    begin_seq(1'b1, 3'd0, 3'd7);
    tick(); tick();
    abort = 1'b1; halt = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; halt = 1'b0; start = 1'b0;
    if (count !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || wrap !== 1'b0) begin failures++; $display("FAIL abort_all got count=%0d busy=%0b done=%0b wrap=%0b exp 0 0 0 0", count, busy, done, wrap); end
    checks++;
    tick();
    if (count !== 3'd0 || busy !== 1'b0) begin failures++; $display("FAIL abort_idle got count=%0d busy=%0b exp 0 0", count, busy); end
    checks++;
    // abort on a terminal cycle drops the done pulse
    begin_seq(1'b0, 3'd3, 3'd3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    if (done !== 1'b0 || count !== 3'd0 || busy !== 1'b0) begin failures++; $display("FAIL abort_terminal got done=%0b count=%0d busy=%0b exp 0 0 0", done, count, busy); end
    checks++;
  endtask

  task automatic test_reset_mid_run();
    begin_seq(1'b0, 3'd5, 3'd7);
    reset_n = 1'b0;
    #1;
    model_reset();
    if (count !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || wrap !== 1'b0) begin failures++; $display("FAIL reset_mid got count=%0d busy=%0b done=%0b wrap=%0b exp 0 0 0 0", count, busy, done, wrap); end
    checks++;
    @(posedge clock); #1;
    reset_n = 1'b1;
    tick();
    if (count !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_after got count=%0d busy=%0b done=%0b exp 0 0 0", count, busy, done); end
    checks++;
  endtask

`ifdef COUNT_SEQ_DOWN_EN
  task automatic test_down();
    logic [2:0] ec [0:4];
    logic       ed [0:4];
    ec = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd2};
    ed = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    down = 1'b1;
    begin_seq(1'b0, 3'd5, 3'd2);
    down = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (count !== ec[i] || done !== ed[i]) begin failures++; $display("FAIL down[%0d] got count=%0d done=%0b exp count=%0d done=%0b", i, count, done, ec[i], ed[i]); end
      checks++;
      tick();
    end
    tick();
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      abort    = ($urandom_range(0, 24) == 0);
      halt     = ($urandom_range(0, 5) == 0);
      start    = ($urandom_range(0, 2) == 0);
      mode     = 1'($urandom_range(0, 1));
      load_val = 3'($urandom_range(0, 7));
      limit    = 3'($urandom_range(0, 7));
`ifdef COUNT_SEQ_DOWN_EN
      down     = 1'($urandom_range(0, 1));
`endif
      tick();
      if (count !== 3'(m_count) || busy !== m_busy || done !== m_done || wrap !== m_wrap) begin
        failures++;
        $display("FAIL random[%0d] got count=%0d busy=%0b done=%0b wrap=%0b exp count=%0d busy=%0b done=%0b wrap=%0b",
                 i, count, busy, done, wrap, m_count, m_busy, m_done, m_wrap);
      end
      checks++;
    end
    abort = 1'b0; halt = 1'b0; start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_freerun();
    test_halt();
    test_wrap_boundary();
    test_equal_limit();
    test_abort();
    test_reset_mid_run();
`ifdef COUNT_SEQ_DOWN_EN
    test_down();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
